input_folding_multilane: RTL



---
 rtl/input_folding_multilane_pkg.sv | 25 ++
 rtl/input_folding_multilane_if.sv | 27 ++
 rtl/input_folding_multilane_folding_bank.sv | 31 +++
 rtl/input_folding_multilane.sv | 111 +++++++++++
 4 files changed

// File: rtl/input_folding_multilane_pkg.sv
// Shared FFT datapath types and elaboration helpers for the input folder.
package input_folding_multilane_pkg;

    localparam int unsigned CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_product_t;

    // Floor log2; exact for the power-of-two sizes used by the folder.
    function automatic int unsigned log2_pow2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= v) r = i;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/input_folding_multilane_if.sv
// Sample stream in, folded L-lane vectors out.
interface input_folding_multilane_if
    import input_folding_multilane_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned IDX_W = 2
) ();

    logic             enable;
    logic             sync;
    complex_product_t data_in;
    complex_product_t data_out [LANES];
    logic [IDX_W-1:0] out_index;
    logic             out_valid;
    logic             out_last;

    modport master (
        output enable, sync, data_in,
        input  data_out, out_index, out_valid, out_last
    );

    modport slave (
        input  enable, sync, data_in,
        output data_out, out_index, out_valid, out_last
    );

endinterface

// File: rtl/input_folding_multilane_folding_bank.sv
// One segment of buffered samples: registered write, combinational read.
module folding_bank
    import input_folding_multilane_pkg::*;
#(
    parameter int unsigned SEG = 4,
    parameter int unsigned AW  = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  complex_product_t wdata,
    input  logic [AW-1:0]    raddr,
    output complex_product_t rdata
);

    // A single-entry segment still gets a 1-bit address, so size to two entries.
    localparam int unsigned DEPTH = (SEG < 2) ? 2 : SEG;

    if (AW != log2_pow2(DEPTH)) begin : g_chk_aw
        $error("folding_bank: AW does not match SEG");
    end

    complex_product_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/input_folding_multilane.sv
// Serial-to-L-lane FFT input folder: buffers the first L-1 segments of a frame,
// then emits x[k], x[k+SEG], ... alongside each sample of the last segment.
module input_folding_multilane
    import input_folding_multilane_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned LANES = 2
) (
    input logic                       clk,
    input logic                       reset,
    input_folding_multilane_if.slave  bus
);

    localparam int unsigned SEG      = N / LANES;
    localparam int unsigned CNT_W    = log2_pow2(N);
    localparam int unsigned OFF_BITS = log2_pow2(SEG);
    localparam int unsigned IDX_W    = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam int unsigned SEL_W    = log2_pow2(LANES);

    localparam logic [SEL_W-1:0] LAST_SEG = SEL_W'(LANES - 1);
    localparam logic [IDX_W-1:0] LAST_OFF = IDX_W'(SEG - 1);
    localparam logic [CNT_W-1:0] OFF_MASK = CNT_W'(SEG - 1);

    if (!is_pow2(N) || N < 2) begin : g_chk_n
        $error("input_folding_multilane: N must be a power of two >= 2");
    end
    if (!is_pow2(LANES) || LANES < 2) begin : g_chk_lanes
        $error("input_folding_multilane: LANES must be a power of two >= 2");
    end
    if (LANES > N) begin : g_chk_ratio
        $error("input_folding_multilane: LANES must not exceed N");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx;
    logic [SEL_W-1:0] seg;
    logic [IDX_W-1:0] off;

    always_comb begin
        idx   = bus.sync ? '0 : cnt_q;
        seg   = SEL_W'(idx >> OFF_BITS);
        off   = IDX_W'(idx & OFF_MASK);
        // N is a power of two, so the natural counter wrap gives N-1 -> 0.
        cnt_d = bus.enable ? idx + CNT_W'(1) : cnt_q;
    end

    complex_product_t bank_rdata [LANES-1];
    logic [LANES-2:0] bank_we;

    for (genvar j = 0; j < LANES - 1; j++) begin : g_bank
        assign bank_we[j] = bus.enable && (seg == SEL_W'(j));

        folding_bank #(
            .SEG (SEG),
            .AW  (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[j]),
            .waddr (off),
            .wdata (bus.data_in),
            .raddr (off),
            .rdata (bank_rdata[j])
        );
    end

    complex_product_t data_out_q [LANES];
    complex_product_t data_out_d [LANES];
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;

    always_comb begin
        data_out_d  = data_out_q;
        out_index_d = out_index_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (bus.enable && (seg == LAST_SEG)) begin
            for (int unsigned j = 0; j < LANES - 1; j++) begin
                data_out_d[j] = bank_rdata[j];
            end
            data_out_d[LANES-1] = bus.data_in;
            out_index_d         = off;
            out_valid_d         = 1'b1;
            out_last_d          = (off == LAST_OFF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int unsigned j = 0; j < LANES; j++) begin
                data_out_q[j] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_index = out_index_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule
